// File: rtl/uart_tx_pkg.sv
// Shared definitions for the extended UART transmitter: FSM state encoding
// and default sizing for the data word, FIFO and prescaler.
package uart_tx_pkg;

  localparam int DEF_DATA_WD     = 8;
  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_PRESCALE_WD = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_tx_ext_if.sv
// Word handshake between a producer and the UART transmitter.
// The producer offers P_DATA with DATA_VALID; the transmitter accepts it on
// any rising edge where DATA_READY is also high.
interface uart_tx_ext_if #(
  parameter int DATA_WD = 8
);

  logic [DATA_WD-1:0] P_DATA;
  logic               DATA_VALID;
  logic               DATA_READY;

  modport master (
    output P_DATA,
    output DATA_VALID,
    input  DATA_READY
  );

  modport slave (
    input  P_DATA,
    input  DATA_VALID,
    output DATA_READY
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// Transmit word FIFO. Pointers carry one extra wrap bit so that full and
// empty can be told apart when the index bits are equal. Writes to a full
// FIFO and reads from an empty one are silently dropped.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_write;
  logic             do_read;

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign do_write = wr_en && !full;
  assign do_read  = rd_en && !empty;
  assign rd_data  = mem[rd_ptr[AW-1:0]];

  // Advance the write/read pointers; reset empties the FIFO.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_read)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge CLK) begin
    if (do_write) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_ext.sv
// UART transmitter with a word FIFO, optional even/odd parity, one or two
// stop bits and a per-frame programmable bit time. Frame settings are
// captured when a word leaves the FIFO so they stay fixed for that frame.
// TX_OUT and Busy are registered and are computed from the transition
// being taken on the same edge, so a new frame shows up one edge after
// the word reaches an empty, idle transmitter.
module uart_tx_ext
  import uart_tx_pkg::*;
#(
  parameter int DATA_WD     = DEF_DATA_WD,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int PRESCALE_WD = DEF_PRESCALE_WD
) (
  input  logic                   CLK,
  input  logic                   RST,
  uart_tx_ext_if.slave           bus,
  input  logic                   PAR_EN,
  input  logic                   PAR_TYP,
  input  logic                   STOP2,
  input  logic [PRESCALE_WD-1:0] PRESCALE,
  output logic                   TX_OUT,
  output logic                   Busy
);

  localparam int                      BIT_CNT_WD = $clog2(DATA_WD);
  localparam logic [BIT_CNT_WD-1:0]   LAST_BIT   = BIT_CNT_WD'(DATA_WD - 1);
  localparam logic [BIT_CNT_WD-1:0]   BIT_ONE    = BIT_CNT_WD'(1);
  localparam logic [PRESCALE_WD-1:0]  PRESC_ONE  = PRESCALE_WD'(1);

  tx_state_e              state;
  tx_state_e              next_state;

  logic [DATA_WD-1:0]     fifo_data;
  logic                   fifo_full;
  logic                   fifo_empty;

  logic [DATA_WD-1:0]     shift_reg;
  logic [BIT_CNT_WD-1:0]  bit_cnt;
  logic                   stop_cnt;
  logic [PRESCALE_WD-1:0] presc_eff;
  logic [PRESCALE_WD-1:0] presc_q;
  logic [PRESCALE_WD-1:0] presc_cnt;
  logic                   par_en_q;
  logic                   stop2_q;
  logic                   parity_q;

  logic                   load_frame;
  logic                   bit_done;
  logic                   last_data_bit;
  logic                   last_stop_bit;
  logic                   tx_next;
  logic                   busy_next;

  uart_tx_fifo #(
    .WIDTH (DATA_WD),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .wr_en   (bus.DATA_VALID),
    .wr_data (bus.P_DATA),
    .rd_en   (load_frame),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign bus.DATA_READY = !fifo_full;

  // A programmed prescale of zero behaves as one cycle per bit.
  assign presc_eff     = (PRESCALE == '0) ? PRESC_ONE : PRESCALE;
  assign bit_done      = (state != IDLE) && (presc_cnt == '0);
  assign last_data_bit = (bit_cnt == LAST_BIT);
  assign last_stop_bit = !stop2_q || stop_cnt;
  assign load_frame    = !fifo_empty &&
                         ((state == IDLE) ||
                          ((state == STOP) && bit_done && last_stop_bit));

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state decode; a bit ends when the prescale counter reaches zero.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!fifo_empty) next_state = START;
      START:   if (bit_done) next_state = DATA;
      DATA:    if (bit_done && last_data_bit) next_state = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_done) next_state = STOP;
      STOP:    if (bit_done && last_stop_bit) next_state = fifo_empty ? IDLE : START;
      default: next_state = IDLE;
    endcase
  end

  // Frame datapath: capture word and settings at frame start, then time
  // each bit with a down-counter reloaded at every bit boundary.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      presc_cnt <= '0;
      presc_q   <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      shift_reg <= '0;
      par_en_q  <= 1'b0;
      stop2_q   <= 1'b0;
      parity_q  <= 1'b0;
    end else if (load_frame) begin
      presc_q   <= presc_eff;
      presc_cnt <= presc_eff - PRESC_ONE;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      shift_reg <= fifo_data;
      par_en_q  <= PAR_EN;
      stop2_q   <= STOP2;
      parity_q  <= (^fifo_data) ^ PAR_TYP;
    end else if (next_state == IDLE) begin
      presc_cnt <= '0;
    end else if (bit_done) begin
      presc_cnt <= presc_q - PRESC_ONE;
      if (state == DATA) begin
        shift_reg <= shift_reg >> 1;
        bit_cnt   <= bit_cnt + BIT_ONE;
      end
      if (state == STOP) stop_cnt <= 1'b1;
    end else begin
      presc_cnt <= presc_cnt - PRESC_ONE;
    end
  end

  // Output decode: the line value for the bit that starts on this edge.
  always_comb begin
    tx_next   = TX_OUT;
    busy_next = Busy;
    if (load_frame) begin
      tx_next   = 1'b0;
      busy_next = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx_next   = 1'b1;
          busy_next = 1'b0;
        end
        START: if (bit_done) tx_next = shift_reg[0];
        DATA: begin
          if (bit_done) begin
            if (last_data_bit) tx_next = par_en_q ? parity_q : 1'b1;
            else               tx_next = shift_reg[1];
          end
        end
        PARITY: if (bit_done) tx_next = 1'b1;
        STOP: begin
          if (bit_done && last_stop_bit) begin
            tx_next   = 1'b1;
            busy_next = 1'b0;
          end
        end
        default: begin
          tx_next   = 1'b1;
          busy_next = 1'b0;
        end
      endcase
    end
  end

  // Registered serial line and busy flag; line idles high.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      TX_OUT <= 1'b1;
      Busy   <= 1'b0;
    end else begin
      TX_OUT <= tx_next;
      Busy   <= busy_next;
    end
  end

endmodule
